lif_scheduler: RTL and testbench
================================

# lif_scheduler

Time-multiplexed controller that shares one leaky-integrate-and-fire update datapath among `N_NEURONS` neurons. It holds per-neuron membrane state and pending input current, and sweeps all neurons once per timestep on a `start` pulse. Each update applies the team's LIF rule, next = current + (state >> 1), with beta = 0.5. Spike events leave the block as a valid/ready stream of neuron indices, which makes this block the sequencer between input injection logic and downstream spike consumers.

## Interface
- `N_NEURONS`, default 4: number of neurons; must be at least 2.
- `THRESHOLD`, default 127: spike threshold, 8-bit, valid range 1..255.
- `IDX_W`, default $clog2(N_NEURONS): neuron index width.
- `clk` input, 1 bit: the single clock; all state updates on its rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: begin one timestep sweep; sampled only in IDLE.
- `cur_valid` input, 1 bit: current-injection write strobe.
- `cur_idx` input, IDX_W bits: target neuron of the injection.
- `cur_data` input, 8 bits: current to add to that neuron's pending accumulator.
- `spike_valid` output, 1 bit: spike event present.
- `spike_idx` output, IDX_W bits: index of the spiking neuron.
- `spike_ready` input, 1 bit: consumer accepts the event.
- `busy` output, 1 bit: high whenever the FSM is not in IDLE.
- `done` output, 1 bit: one-cycle pulse at the end of a sweep.
- `mon_idx` input, IDX_W bits: membrane readback select.
- `mon_state` output, 8 bits: combinational readback of membrane state for `mon_idx`.

## Operation
- Storage is per neuron:
  - `mem[i]`, 8 bits: membrane state.
  - `acc[i]`, 8 bits: pending current.
- Injection: when `cur_valid` is high, `acc[cur_idx] <= sat255(acc[cur_idx] + cur_data)`.
  - Injection is accepted in every FSM state.
  - An out-of-range `cur_idx` (at or above N_NEURONS) is ignored.
- FSM states are IDLE, UPDATE, EMIT and DONE. The neuron pointer `ptr` is IDX_W bits.
  - IDLE: if `start` is high, set ptr = 0 and go to UPDATE. `start` outside IDLE is ignored, with no queuing.
  - UPDATE (one cycle per neuron):
    - Compute `nxt = sat255(acc[ptr] + (mem[ptr] >> 1))`, using 9-bit intermediate and saturation at 255.
    - Clear `acc[ptr]`.
    - If `nxt >= THRESHOLD`: write `mem[ptr] <= 0`, latch `spike_idx <= ptr` and go to EMIT.
    - Otherwise write `mem[ptr] <= nxt`. Then, if ptr == N_NEURONS-1, go to DONE; else increment ptr and stay in UPDATE.
  - EMIT:
    - `spike_valid` is high, and `spike_idx` is stable, until a cycle with `spike_valid && spike_ready`.
    - On that handshake, go to DONE if ptr == N_NEURONS-1; otherwise increment ptr and go to UPDATE.
  - DONE: `done` is high for one cycle, then go to IDLE.
- Simultaneous consume and inject: if `cur_valid` targets `ptr` in its UPDATE cycle, the old acc value is consumed by this update and `acc[ptr] <= sat255(cur_data)`. That new value belongs to the next timestep.
- Spike is reset-to-zero (no subtraction). The membrane never wraps.
- Neurons with zero input leak by halving each timestep.

## Timing
- Reset values: `spike_valid`=0, `spike_idx`=0, `busy`=0, `done`=0, all `mem`=0, all `acc`=0, ptr=0, FSM in IDLE.
  - `mon_state` therefore reads 0.
  - Reset takes effect immediately and asynchronously, including mid-sweep or mid-EMIT. Any pending spike is dropped.
- Sweep latency without spikes, with `start` sampled at edge 0:
  - UPDATE occupies cycles 1..N_NEURONS.
  - `done` is high in cycle N_NEURONS+1.
  - `busy` is high in cycles 1..N_NEURONS+1.
- Each spike inserts EMIT cycles: at least 1, plus one per cycle `spike_ready` is low.
- `spike_valid` asserts in the cycle after the spiking neuron's UPDATE.
- `spike_valid` never deasserts without a handshake, except on reset.
- A `mem` write is visible on `mon_state` in the cycle after its UPDATE.
- At most one spike is outstanding; no event buffering.

## Test plan
- Reset and idle:
  - Assert `rst` mid-sweep -> all outputs 0 immediately.
  - `start` after reset release -> `done` 5 cycles later (N=4), with no `spike_valid`.
- Integrate then leak:
  - Inject 100 into neuron 0, then `start` -> `mem[0]`=100, no spike.
  - Two further empty sweeps -> 50, then 25.
- Spike with backpressure:
  - Start from `mem[1]`=50 and inject 110 (25+110=135 >= 127). Hold `spike_ready` low 3 cycles.
  - Required: `spike_valid` high 4 cycles with `spike_idx`=1, `mem[1]`=0, `done` delayed by 4 cycles versus no-spike.
- Saturation: inject 200 twice into neuron 2, then `start` -> acc saturates at 255, spike on idx 2, `mem[2]`=0.
- Simultaneous inject/consume:
  - Inject 30 into neuron 3 before `start`, then inject 40 into neuron 3 during its UPDATE cycle.
  - Required: `mem[3]`=30, and `mem[3]`=15+40=55 after the next sweep.
- Start while busy:
  - Pulse `start` during UPDATE and during DONE -> ignored.
  - Exactly one `done` pulse results, and `busy` falls in the cycle after `done`.

Source files
------------

// File: rtl/lif_scheduler.sv
// rtl/lif_scheduler.sv - time-multiplexed leaky-integrate-and-fire neuron sweep controller
module lif_scheduler #(
    parameter int N_NEURONS = 4,
    parameter int THRESHOLD = 127,
    parameter int IDX_W     = $clog2(N_NEURONS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_cur_valid,
    input  logic [IDX_W-1:0] i_cur_idx,
    input  logic [7:0]       i_cur_data,
    output logic             o_spike_valid,
    output logic [IDX_W-1:0] o_spike_idx,
    input  logic             i_spike_ready,
    output logic             o_busy,
    output logic             o_done,
    input  logic [IDX_W-1:0] i_mon_idx,
    output logic [7:0]       o_mon_state
);

    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_EMIT, S_DONE} state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [7:0]       r_mem [N_NEURONS];
    logic [7:0]       r_acc [N_NEURONS];
    logic             r_spike_valid;
    logic [IDX_W-1:0] r_spike_idx;
    logic             r_busy;
    logic             r_done;

    logic [7:0]       w_nxt;
    logic             w_fire;
    logic             w_last;
    logic             w_update_hit;
    logic             w_mon_ok;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    assign w_nxt        = sat_add(r_acc[r_ptr], {1'b0, r_mem[r_ptr][7:1]});
    assign w_fire       = (w_nxt >= 8'(THRESHOLD));
    assign w_last       = (r_ptr == IDX_W'(N_NEURONS - 1));
    // An injection aimed at the neuron being updated lands after the consume.
    assign w_update_hit = (r_state == S_UPDATE) && i_cur_valid && (i_cur_idx == r_ptr);
    assign w_mon_ok     = ({1'b0, i_mon_idx} < (IDX_W + 1)'(N_NEURONS));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_spike_valid <= 1'b0;
            r_spike_idx   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) r_mem[i] <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    if (w_fire) begin
                        r_mem[r_ptr]  <= 8'd0;
                        r_spike_idx   <= r_ptr;
                        r_spike_valid <= 1'b1;
                        r_state       <= S_EMIT;
                    end else begin
                        r_mem[r_ptr] <= w_nxt;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_ptr <= r_ptr + IDX_W'(1);
                        end
                    end
                end
                S_EMIT: begin
                    if (i_spike_ready) begin
                        r_spike_valid <= 1'b0;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_ptr   <= r_ptr + IDX_W'(1);
                            r_state <= S_UPDATE;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < N_NEURONS; i++) r_acc[i] <= 8'd0;
        end else begin
            for (int i = 0; i < N_NEURONS; i++) begin
                if ((r_state == S_UPDATE) && (r_ptr == IDX_W'(i))) begin
                    r_acc[i] <= w_update_hit ? i_cur_data : 8'd0;
                end else if (i_cur_valid && (i_cur_idx == IDX_W'(i))) begin
                    r_acc[i] <= sat_add(r_acc[i], i_cur_data);
                end
            end
        end
    end

    assign o_spike_valid = r_spike_valid;
    assign o_spike_idx   = r_spike_idx;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_mon_state   = w_mon_ok ? r_mem[i_mon_idx] : 8'd0;

endmodule

// File: tb/tb_lif_scheduler.sv
// tb/tb_lif_scheduler.sv - scoreboard bench for lif_scheduler (N_NEURONS=4, THRESHOLD=127)
module tb_lif_scheduler;

    logic       clk, rst, start, cur_valid, spike_ready;
    logic [1:0] cur_idx, mon_idx;
    logic [7:0] cur_data;
    logic       spike_valid, busy, done;
    logic [1:0] spike_idx;
    logic [7:0] mon_state;

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [1:0] exp_q[$];

    lif_scheduler #(.N_NEURONS(4), .THRESHOLD(127)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_cur_valid(cur_valid), .i_cur_idx(cur_idx), .i_cur_data(cur_data),
        .o_spike_valid(spike_valid), .o_spike_idx(spike_idx), .i_spike_ready(spike_ready),
        .o_busy(busy), .o_done(done), .i_mon_idx(mon_idx), .o_mon_state(mon_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic inject(input logic [1:0] idx, input logic [7:0] d);
        cur_valid = 1'b1; cur_idx = idx; cur_data = d;
        tick();
        cur_valid = 1'b0;
    endtask

    // One sweep; pops the spike scoreboard on every handshake. lat = cycle of done.
    task automatic do_sweep(input int ready_low, input int mid_c, input logic [7:0] mid_data,
                            input bit poke, output int lat, output int vcyc);
        int vcount;
        logic [1:0] e;
        lat = 0; vcyc = 0; vcount = 0;
        spike_ready = (ready_low == 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 100 && lat == 0; c++) begin
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b1) begin
                n_fail++; $display("FAIL busy_in_sweep: cycle %0d got %0b expected 1", c, busy);
            end
            cur_valid = (c == mid_c); cur_idx = 2'd3; cur_data = mid_data;
            start = poke && (c == 2);
            if (spike_valid) begin
                vcyc++; vcount++;
                if (vcount == ready_low + 1) begin
                    spike_ready = 1'b1;
                    vcount = 0;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_fail++; $display("FAIL spike_unexpected: got idx %0d expected none", spike_idx);
                    end else begin
                        e = exp_q.pop_front();
                        if (spike_idx !== e) begin
                            n_fail++; $display("FAIL spike_idx: got %0d expected %0d", spike_idx, e);
                        end
                    end
                end
            end else if (ready_low != 0) begin
                spike_ready = 1'b0;
            end
            if (done) begin
                lat = c;
                if (poke) start = 1'b1;
            end
        end
        n_cmp++;
        if (lat == 0) begin
            n_fail++; $display("FAIL done_timeout: got no done expected done within 100 cycles");
        end
        @(negedge clk);
        start = 1'b0; cur_valid = 1'b0; spike_ready = 1'b1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL busy_after_done: got busy=%0b done=%0b expected 0 0", busy, done);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL spike_missing: got %0d left in queue expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        logic [7:0] m;
        rst = 1'b1; start = 1'b0; cur_valid = 1'b0; cur_idx = '0; cur_data = '0;
        spike_ready = 1'b1; mon_idx = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({spike_valid, spike_idx, busy, done} !== 5'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected 00000", {spike_valid, spike_idx, busy, done});
        end
        for (int i = 0; i < 4; i++) begin
            mon_idx = 2'(i); #1; m = mon_state;
            n_cmp++;
            if (m !== 8'd0) begin
                n_fail++; $display("FAIL reset_mem%0d: got %0d expected 0", i, m);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int lat, vcyc;
        inject(2'd0, 8'd200);
        spike_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 20 && !spike_valid; c++) @(negedge clk);
        n_cmp++;
        if (spike_valid !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_spike: got %0b expected 1", spike_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({spike_valid, spike_idx, busy, done} !== 5'b0) begin
            n_fail++; $display("FAIL async_reset: got %b expected 00000", {spike_valid, spike_idx, busy, done});
        end
        for (int i = 0; i < 4; i++) begin
            mon_idx = 2'(i); #1;
            n_cmp++;
            if (mon_state !== 8'd0) begin
                n_fail++; $display("FAIL async_reset_mem%0d: got %0d expected 0", i, mon_state);
            end
        end
        @(posedge clk); #1 rst = 1'b0;
        spike_ready = 1'b1;
        do_sweep(0, 0, 8'd0, 1'b0, lat, vcyc);
        n_cmp++;
        if (lat != 5 || vcyc != 0) begin
            n_fail++; $display("FAIL post_reset_sweep: got lat=%0d valid=%0d expected 5 0", lat, vcyc);
        end
    endtask

    task automatic test_integrate_leak();
        int lat, vcyc;
        logic [7:0] exp_m [3][4];
        exp_m = '{'{8'd100, 8'd0, 8'd0, 8'd0}, '{8'd50, 8'd100, 8'd0, 8'd0}, '{8'd25, 8'd50, 8'd0, 8'd0}};
        for (int s = 0; s < 3; s++) begin
            if (s == 0) inject(2'd0, 8'd100);
            if (s == 1) inject(2'd1, 8'd100);
            do_sweep(0, 0, 8'd0, 1'b0, lat, vcyc);
            n_cmp++;
            if (lat != 5 || vcyc != 0) begin
                n_fail++; $display("FAIL leak_sweep%0d: got lat=%0d valid=%0d expected 5 0", s, lat, vcyc);
            end
            for (int i = 0; i < 4; i++) begin
                mon_idx = 2'(i); #1;
                n_cmp++;
                if (mon_state !== exp_m[s][i]) begin
                    n_fail++; $display("FAIL leak_mem%0d_s%0d: got %0d expected %0d", i, s, mon_state, exp_m[s][i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int lat, vcyc;
        inject(2'd1, 8'd110);
        exp_q.push_back(2'd1);
        do_sweep(3, 0, 8'd0, 1'b0, lat, vcyc);
        n_cmp++;
        if (lat != 9 || vcyc != 4) begin
            n_fail++; $display("FAIL backpressure: got lat=%0d valid=%0d expected 9 4", lat, vcyc);
        end
        mon_idx = 2'd1; #1;
        n_cmp++;
        if (mon_state !== 8'd0) begin
            n_fail++; $display("FAIL bp_mem1: got %0d expected 0", mon_state);
        end
        mon_idx = 2'd0; #1;
        n_cmp++;
        if (mon_state !== 8'd12) begin
            n_fail++; $display("FAIL bp_mem0: got %0d expected 12", mon_state);
        end
    endtask

    task automatic test_saturation();
        int lat, vcyc;
        inject(2'd2, 8'd200);
        inject(2'd2, 8'd200);
        inject(2'd3, 8'd255);
        inject(2'd3, 8'd2);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        do_sweep(0, 0, 8'd0, 1'b0, lat, vcyc);
        n_cmp++;
        if (lat != 7 || vcyc != 2) begin
            n_fail++; $display("FAIL saturation: got lat=%0d valid=%0d expected 7 2", lat, vcyc);
        end
        mon_idx = 2'd2; #1;
        n_cmp++;
        if (mon_state !== 8'd0) begin
            n_fail++; $display("FAIL sat_mem2: got %0d expected 0", mon_state);
        end
    endtask

    task automatic test_simultaneous();
        int lat, vcyc;
        inject(2'd3, 8'd30);
        do_sweep(0, 4, 8'd40, 1'b0, lat, vcyc);
        mon_idx = 2'd3; #1;
        n_cmp++;
        if (lat != 5 || mon_state !== 8'd30) begin
            n_fail++; $display("FAIL simul_first: got lat=%0d mem3=%0d expected 5 30", lat, mon_state);
        end
        do_sweep(0, 0, 8'd0, 1'b0, lat, vcyc);
        mon_idx = 2'd3; #1;
        n_cmp++;
        if (mon_state !== 8'd55) begin
            n_fail++; $display("FAIL simul_second: got mem3=%0d expected 55", mon_state);
        end
    endtask

    task automatic test_start_busy();
        int lat, vcyc, extra;
        do_sweep(0, 0, 8'd0, 1'b1, lat, vcyc);
        n_cmp++;
        if (lat != 5) begin
            n_fail++; $display("FAIL start_busy_lat: got %0d expected 5", lat);
        end
        extra = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_fail++; $display("FAIL start_busy_extra: got %0d active cycles expected 0", extra);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_sweep();
        test_integrate_leak();
        test_backpressure();
        test_saturation();
        test_simultaneous();
        test_start_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
